// File: rtl/drca_seq_pkg.sv
// rtl/drca_seq_pkg.sv - shared types and sizing helpers for the DRCA sequencer
//   Contents: seq_state_t (IDLE, LAUNCH, WAIT, DONE), cnt_width(), worst_stages().
package drca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    // A full N-bit ripple is N bit stages plus the carry-in stage.
    localparam int WORST_STAGES_EXTRA = 1;

    // Width of the settle-time down-counter. It must hold the worst-case load of (N+1)*STAGE_CYCLES.
    function automatic int cnt_width(input int n, input int stage_cycles);
        return $clog2((n + WORST_STAGES_EXTRA) * stage_cycles + 1);
    endfunction

    // Number of stages in the full carry chain.
    function automatic int worst_stages(input int n);
        return n + WORST_STAGES_EXTRA;
    endfunction

endpackage

// File: rtl/prop_run_len.sv
// rtl/prop_run_len.sv - longest run of consecutive 1s in a propagate vector
//   p   in  N               propagate vector
//   run out clog2(N+1)      longest run of 1s, 0..N
module prop_run_len #(
    parameter int N = 32
) (
    input  logic [N-1:0]             p,
    output logic [$clog2(N+1)-1:0]   run
);

    localparam int RW = $clog2(N + 1);

    int cur;
    int best;

    always_comb begin
        cur  = 0;
        best = 0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                cur = cur + 1;
            end else begin
                cur = 0;
            end
            if (cur > best) begin
                best = cur;
            end
        end
        run = RW'(best);
    end

endmodule

// File: rtl/drca_sequencer.sv
// rtl/drca_sequencer.sv - sequences operand triples through one DRCA with data-dependent settle time
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_cin  operand handshake
//   out_valid/out_ready/out_sum       result handshake, out_sum = {Cout,S}
//   cfg_worst_case                    always wait the full-chain time
//   stat_clear/stat_ops/stat_busy     saturating statistics
//   drca_*                            interface to the attached DRCA
module drca_sequencer
    import drca_seq_pkg::*;
#(
    parameter int N            = 32,
    parameter int STAGE_CYCLES = 1,
    parameter int STAT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_a,
    input  logic [N-1:0]      in_b,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N:0]        out_sum,
    input  logic              cfg_worst_case,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_busy,
    output logic              drca_enable,
    output logic [N-1:0]      drca_a,
    output logic [N-1:0]      drca_b,
    output logic              drca_cin,
    input  logic [N-1:0]      drca_s,
    input  logic              drca_cout,
    input  logic [N-1:0]      drca_p
);

    localparam int CW      = cnt_width(N, STAGE_CYCLES);
    localparam int RW      = $clog2(N + 1);
    localparam int WORST_W = worst_stages(N) * STAGE_CYCLES;

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic            op_cin;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   w_val;
    logic [RW-1:0]   run;

    prop_run_len #(.N(N)) u_run (
        .p   (drca_p),
        .run (run)
    );

    // A run of R propagating bits means the carry crosses R+1 stages.
    always_comb begin
        if (cfg_worst_case) begin
            w_val = CW'(WORST_W);
        end else begin
            w_val = CW'((int'(run) + 1) * STAGE_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        drca_enable = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                drca_enable = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                drca_enable = 1'b1;
                if (cnt <= CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);

    // The DRCA sees the operand registers directly, so its inputs only move on an IDLE accept.
    assign drca_a   = op_a;
    assign drca_b   = op_b;
    assign drca_cin = op_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            op_cin  <= 1'b0;
            cnt     <= '0;
            out_sum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a   <= in_a;
                        op_b   <= in_b;
                        op_cin <= in_cin;
                    end
                end
                LAUNCH: begin
                    cnt <= w_val;
                end
                WAIT: begin
                    if (cnt > CW'(1)) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        out_sum <= {drca_cout, drca_s};
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear wins over a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            stat_ops  <= '0;
            stat_busy <= '0;
        end else begin
            if (state == DONE && out_ready && stat_ops != '1) begin
                stat_ops <= stat_ops + STAT_W'(1);
            end
            if ((state == LAUNCH || state == WAIT) && stat_busy != '1) begin
                stat_busy <= stat_busy + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_drca_sequencer.sv
// tb/tb_drca_sequencer.sv - self-checking bench for drca_sequencer with a behavioural DRCA and reference model
module tb_drca_sequencer;

    localparam int N   = 8;
    localparam int SC  = 2;
    localparam int SW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    out_sum;
    logic          cfg_worst_case;
    logic          stat_clear;
    logic [SW-1:0] stat_ops;
    logic [SW-1:0] stat_busy;
    logic          drca_enable;
    logic [N-1:0]  drca_a;
    logic [N-1:0]  drca_b;
    logic          drca_cin;
    logic [N-1:0]  drca_s;
    logic          drca_cout;
    logic [N-1:0]  drca_p;

    logic [N-1:0]  pr_p;
    logic [3:0]    pr_run;

    int total = 0;
    int bad   = 0;
    int m_ops = 0;
    int m_busy = 0;

    always #5 clk = ~clk;

    // Behavioural DRCA: settled sum and propagate vector of its current inputs.
    assign {drca_cout, drca_s} = {1'b0, drca_a} + {1'b0, drca_b} + {8'd0, drca_cin};
    assign drca_p = drca_a ^ drca_b;

    drca_sequencer #(.N(N), .STAGE_CYCLES(SC), .STAT_W(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_cin         (in_cin),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sum        (out_sum),
        .cfg_worst_case (cfg_worst_case),
        .stat_clear     (stat_clear),
        .stat_ops       (stat_ops),
        .stat_busy      (stat_busy),
        .drca_enable    (drca_enable),
        .drca_a         (drca_a),
        .drca_b         (drca_b),
        .drca_cin       (drca_cin),
        .drca_s         (drca_s),
        .drca_cout      (drca_cout),
        .drca_p         (drca_p)
    );

    prop_run_len #(.N(N)) u_pr (
        .p   (pr_p),
        .run (pr_run)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Longest run of 1s: number of x &= x>>1 steps until x empties.
    function automatic int ref_run(input logic [N-1:0] p);
        logic [N-1:0] x;
        int r;
        x = p;
        r = 0;
        while (x != '0) begin
            x = x & (x >> 1);
            r++;
        end
        return r;
    endfunction

    function automatic int ref_w(input logic [N-1:0] a, input logic [N-1:0] b, input logic wc);
        return wc ? (N + 1) * SC : (ref_run(a ^ b) + 1) * SC;
    endfunction

    function automatic int sat_add(input int v, input int inc);
        return (v + inc > SAT) ? SAT : v + inc;
    endfunction

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input logic wc, input int hold, input logic sclr);
        int w;
        int lat;
        logic [N:0] exp_sum;
        logic [N:0] held;
        w = ref_w(a, b, wc);
        exp_sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        cfg_worst_case = wc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                cfg_worst_case = $urandom_range(0, 1);
                check("enable_busy", 32'(drca_enable), 32'd1);
                check("in_ready_busy", 32'(in_ready), 32'd0);
            end
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'(w + 1));
        check("out_sum", 32'(out_sum), 32'(exp_sum));
        check("enable_done", 32'(drca_enable), 32'd0);
        m_busy = sat_add(m_busy, w + 1);
        held = out_sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_ops", 32'(stat_ops), 32'(m_ops));
        end
        @(negedge clk);
        out_ready = 1'b1;
        stat_clear = sclr;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        stat_clear = 1'b0;
        if (sclr) begin
            m_ops = 0;
            m_busy = 0;
        end else begin
            m_ops = sat_add(m_ops, 1);
        end
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("stat_ops", 32'(stat_ops), 32'(m_ops));
        check("stat_busy", 32'(stat_busy), 32'(m_busy));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        cfg_worst_case = 1'b0;
        stat_clear = 1'b0;
        pr_p = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_enable", 32'(drca_enable), 32'd0);
        check("rst_drca_a", 32'(drca_a), 32'd0);
        check("rst_stat_ops", 32'(stat_ops), 32'd0);
        check("rst_stat_busy", 32'(stat_busy), 32'd0);

        // Standalone run-length unit: boundaries, disjoint runs, then random vectors.
        pr_p = 8'h00; #1 check("run_zero", 32'(pr_run), 32'd0);
        pr_p = 8'hFF; #1 check("run_ones", 32'(pr_run), 32'd8);
        pr_p = 8'h76; #1 check("run_0x76", 32'(pr_run), 32'd3);
        for (int i = 0; i < 16; i++) begin
            pr_p = $urandom;
            #1 check("run_rand", 32'(pr_run), 32'(ref_run(pr_p)));
        end

        // Directed operations: run length 4, full chain, empty chain, worst-case mode.
        run_op(8'h0F, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        check("t1_busy", 32'(stat_busy), 32'd11);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        check("t2_ops", 32'(stat_ops), 32'd3);
        run_op(8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        run_op(8'h35, 8'h5A, 1'b1, 1'b0, 5, 1'b0);

        // Reset in the middle of WAIT drops the operation and the statistics.
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 8'hFF;
        in_b = 8'h00;
        in_cin = 1'b1;
        cfg_worst_case = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ops = 0;
        m_busy = 0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_enable", 32'(drca_enable), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_ops", 32'(stat_ops), 32'd0);
        check("mid_rst_busy", 32'(stat_busy), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 1'b0);

        // Clear coincident with an output handshake.
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1, 1'b1);
        check("clear_ops", 32'(stat_ops), 32'd0);

        // Back-to-back random operations drive both counters into saturation.
        for (int i = 0; i < 20; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   $urandom_range(0, 2), 1'b0);
        end
        check("sat_ops", 32'(stat_ops), 32'd15);
        check("sat_busy", 32'(stat_busy), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
